fm_streamer: RTL and testbench
==============================

FM_STREAMER -- requirements
Module: fm_streamer

Interface
REQ-001 Parameter FM_SIZE, default 2, meaning unpadded feature-map width and height in pixels.
REQ-002 Parameter PADDING, default 0, meaning zero-pixel border added on each side; padded size PS = FM_SIZE+2*PADDING.
REQ-003 Parameter ADDR_W, default $clog2(FM_SIZE*FM_SIZE) (minimum 1), meaning read-address width.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  frame request, sampled only in IDLE.
REQ-007 o_rd_en  output  1  feature-map memory read strobe.
REQ-008 o_rd_addr  output  ADDR_W  raster address of the unpadded pixel, row*FM_SIZE+col.
REQ-009 i_rd_data  input  30 signed  memory read data, valid exactly 1 cycle after o_rd_en.
REQ-010 o_DataFM  output  30 signed  pixel stream into the PE A input.
REQ-011 o_en  output  1  stream-valid, drives the PE i_en.
REQ-012 o_busy  output  1  high from start acceptance until o_done.
REQ-013 o_done  output  1  one-cycle pulse when a frame has been fully sent.

Function
REQ-014 States: IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on i_start; STREAM->DRAIN after issuing padded pixel PS*PS-1; DRAIN->DONE after the final output cycle; DONE->IDLE unconditionally.
REQ-015 Padded row/col counters walk 0..PS-1 in raster order, col fastest, one pixel per cycle, no stalls.
REQ-016 Pixel at (r,c) is a pad when r<PADDING, r>=PADDING+FM_SIZE, c<PADDING or c>=PADDING+FM_SIZE.
REQ-017 Non-pad pixel: o_rd_en=1 and o_rd_addr=(r-PADDING)*FM_SIZE+(c-PADDING) in its issue cycle; pad pixel: o_rd_en=0, no read.
REQ-018 o_DataFM/o_en are registered one cycle after issue: o_DataFM = pad ? 0 : i_rd_data (sign preserved), o_en=1.
REQ-019 Latency: i_start high in IDLE at edge t -> first o_en=1 at edge t+2; o_en then stays high for exactly PS*PS consecutive cycles.
REQ-020 o_done pulses in the cycle after the last o_en=1 cycle; o_busy falls with it.
REQ-021 o_en is 0 and o_DataFM is 0 whenever no pixel is presented.
REQ-022 i_start outside IDLE is ignored and not queued; o_en therefore drops for at least 2 cycles between frames, resetting the PE counters.
REQ-023 PADDING=0 issues exactly FM_SIZE*FM_SIZE reads; PADDING>0 issues exactly FM_SIZE*FM_SIZE reads and PS*PS-FM_SIZE*FM_SIZE zero pixels.
REQ-024 FM_SIZE=1 with PADDING=0 is legal: one pixel, one o_en cycle, then o_done.
REQ-025 Address counter never exceeds FM_SIZE*FM_SIZE-1; no wrap inside a frame.

Reset
REQ-026 Asserting i_rst_n low at any time, including mid-frame, forces IDLE, counters 0, o_en=0, o_rd_en=0, o_rd_addr=0, o_DataFM=0, o_busy=0, o_done=0 immediately.
REQ-027 After reset release the block waits for a fresh i_start; no partial frame resumes.

Structure
REQ-028 Shared package holds the state enum, the 30-bit data width constant and the padded-size function.
REQ-029 Single flat module; no sub-module required, the memory is external.

Verification
REQ-030 FM_SIZE=3, PADDING=0, mem=1..9, start pulse -> reads addr 0..8 consecutive, o_DataFM 1..9 on 9 consecutive o_en cycles starting 2 edges after start, o_done next cycle.
REQ-031 FM_SIZE=2, PADDING=1, mem={10,11,12,13} -> 16 o_en cycles carrying 0,0,0,0,0,10,11,0,0,12,13,0,0,0,0,0; o_rd_en high exactly 4 cycles.
REQ-032 mem[0]=-5 -> o_DataFM=30'h3FFFFFFB on first valid cycle.
REQ-033 i_start held high continuously -> frames separated by >=2 cycles with o_en=0; no start accepted while o_busy.
REQ-034 i_rst_n low at 5th o_en cycle -> all outputs 0 same cycle; next start yields a complete, correct frame.
REQ-035 FM_SIZE=1, PADDING=0, mem={7} -> single o_en cycle with 7, then o_done.

Source files
------------

// File: rtl/fm_streamer_pkg.sv
// fm_streamer_pkg: shared FSM state type, pixel data width and padded-size helper
package fm_streamer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    localparam int DATA_W = 30;

    function automatic int padded_size(input int fm, input int pad);
        return fm + 2 * pad;
    endfunction

endpackage

// File: rtl/fm_streamer.sv
// fm_streamer: streams one (optionally zero-padded) feature map from external memory into a PE
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             frame request, honoured only in IDLE
//   o_rd_en, o_rd_addr  memory read strobe and raster address of the unpadded pixel
//   i_rd_data           memory data, valid one cycle after o_rd_en
//   o_DataFM, o_en      registered pixel stream and its valid
//   o_busy, o_done      frame in progress, one-cycle end-of-frame pulse
module fm_streamer
    import fm_streamer_pkg::*;
#(
    parameter int FM_SIZE = 2,
    parameter int PADDING = 0,
    parameter int ADDR_W  = (FM_SIZE * FM_SIZE > 1) ? $clog2(FM_SIZE * FM_SIZE) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    output logic                     o_rd_en,
    output logic [ADDR_W-1:0]        o_rd_addr,
    input  logic signed [DATA_W-1:0] i_rd_data,
    output logic signed [DATA_W-1:0] o_DataFM,
    output logic                     o_en,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int PS        = padded_size(FM_SIZE, PADDING);
    localparam int CW        = (PS > 1) ? $clog2(PS) : 1;
    localparam int LAST_ADDR = FM_SIZE * FM_SIZE - 1;

    state_t            state, state_nx;
    logic [CW-1:0]     row, col;
    logic [ADDR_W-1:0] addr;
    logic              issue, pad, last_col, last_px;
    // one-cycle delayed copy of the issue slot, aligned with i_rd_data
    logic              vld_q, pad_q;

    assign issue    = state == S_STREAM;
    assign pad      = int'(row) < PADDING || int'(row) >= PADDING + FM_SIZE ||
                      int'(col) < PADDING || int'(col) >= PADDING + FM_SIZE;
    assign last_col = col == CW'(PS - 1);
    assign last_px  = last_col && row == CW'(PS - 1);
    assign o_rd_en   = issue && !pad;
    assign o_rd_addr = addr;
    assign o_busy    = state == S_STREAM || state == S_DRAIN;
    assign o_done    = state == S_DONE;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = i_start ? S_STREAM : S_IDLE;
            S_STREAM: state_nx = last_px ? S_DRAIN : S_STREAM;
            // vld_q is high in the first drain cycle only; the second one presents the last pixel
            S_DRAIN:  state_nx = vld_q ? S_DRAIN : S_DONE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            col      <= '0;
            addr     <= '0;
            vld_q    <= 1'b0;
            pad_q    <= 1'b0;
            o_en     <= 1'b0;
            o_DataFM <= '0;
        end else begin
            state    <= state_nx;
            vld_q    <= issue;
            pad_q    <= pad;
            o_en     <= vld_q;
            o_DataFM <= (vld_q && !pad_q) ? i_rd_data : '0;
            if (issue) begin
                col  <= last_col ? '0 : col + 1'b1;
                row  <= last_col ? (last_px ? '0 : row + 1'b1) : row;
                // saturate at the last pixel so the address never wraps within a frame
                addr <= (o_rd_en && addr != ADDR_W'(LAST_ADDR)) ? addr + 1'b1 : addr;
            end else begin
                row  <= '0;
                col  <= '0;
                addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fm_streamer.sv
// tb_fm_streamer: self-checking bench for fm_streamer over three size/padding configurations
module tb_fm_streamer;
    import fm_streamer_pkg::*;

    typedef struct packed {
        logic [1:0]         inst;
        logic [4:0]         len;
        logic [3:0]         reads;
        logic [8:0][29:0]   mem;
        logic [15:0][29:0]  exp;
    } case_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n, start, rd_en, en, busy, done;
    logic [3:0] addr0;
    logic [1:0] addr1;
    logic [0:0] addr2;
    logic signed [29:0] rd0, rd1, rd2, d0, d1, d2;
    logic signed [29:0] mem0 [9];
    logic signed [29:0] mem1 [4];
    logic signed [29:0] mem2 [1];

    fm_streamer #(.FM_SIZE(3), .PADDING(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .o_rd_en(rd_en[0]),
        .o_rd_addr(addr0), .i_rd_data(rd0), .o_DataFM(d0), .o_en(en[0]),
        .o_busy(busy[0]), .o_done(done[0]));
    fm_streamer #(.FM_SIZE(2), .PADDING(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .o_rd_en(rd_en[1]),
        .o_rd_addr(addr1), .i_rd_data(rd1), .o_DataFM(d1), .o_en(en[1]),
        .o_busy(busy[1]), .o_done(done[1]));
    fm_streamer #(.FM_SIZE(1), .PADDING(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_start(start[2]), .o_rd_en(rd_en[2]),
        .o_rd_addr(addr2), .i_rd_data(rd2), .o_DataFM(d2), .o_en(en[2]),
        .o_busy(busy[2]), .o_done(done[2]));

    always @(posedge clk) begin
        if (rd_en[0]) rd0 <= mem0[addr0];
        if (rd_en[1]) rd1 <= mem1[addr1];
        if (rd_en[2]) rd2 <= mem2[addr2];
    end

    int sel = 0;
    logic s_en, s_rd, s_busy, s_done;
    logic [3:0] s_addr;
    logic signed [29:0] s_d;

    always_comb begin
        s_en   = en[sel];
        s_rd   = rd_en[sel];
        s_busy = busy[sel];
        s_done = done[sel];
        s_addr = sel == 0 ? addr0 : sel == 1 ? {2'b0, addr1} : {3'b0, addr2};
        s_d    = sel == 0 ? d0 : sel == 1 ? d1 : d2;
    end

    int checks = 0;
    int failures = 0;
    logic signed [29:0] sb [$];
    int pat1 [16] = '{0, 0, 0, 0, 0, 10, 11, 0, 0, 12, 13, 0, 0, 0, 0, 0};
    case_t tbl [6];

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_idle(input string nm);
        check({nm, " o_en"}, longint'(s_en), 0);
        check({nm, " o_rd_en"}, longint'(s_rd), 0);
        check({nm, " o_rd_addr"}, longint'(s_addr), 0);
        check({nm, " o_DataFM"}, longint'(s_d), 0);
        check({nm, " o_busy"}, longint'(s_busy), 0);
        check({nm, " o_done"}, longint'(s_done), 0);
    endtask

    task automatic model(inout case_t tc);
        int fm, pd, ps;
        fm = tc.inst == 0 ? 3 : tc.inst == 1 ? 2 : 1;
        pd = tc.inst == 1 ? 1 : 0;
        ps = fm + 2 * pd;
        tc.exp = '0;
        for (int r = 0; r < ps; r++)
            for (int c = 0; c < ps; c++)
                if (r >= pd && r < pd + fm && c >= pd && c < pd + fm)
                    tc.exp[r * ps + c] = tc.mem[(r - pd) * fm + (c - pd)];
        tc.len   = 5'(ps * ps);
        tc.reads = 4'(fm * fm);
    endtask

    task automatic load(input case_t tc);
        for (int i = 0; i < 9; i++) begin
            if (tc.inst == 0) mem0[i] = $signed(tc.mem[i]);
            if (tc.inst == 1 && i < 4) mem1[i] = $signed(tc.mem[i]);
            if (tc.inst == 2 && i < 1) mem2[i] = $signed(tc.mem[i]);
        end
    endtask

    task automatic run_frame(input case_t tc, input string nm, output longint first_d);
        int nen, nrd, first_e, last_e;
        bit got_done;
        sel = int'(tc.inst);
        load(tc);
        sb.delete();
        for (int i = 0; i < int'(tc.len); i++) sb.push_back($signed(tc.exp[i]));
        nen = 0; nrd = 0; first_e = -1; last_e = -1; got_done = 0; first_d = 0;
        @(negedge clk);
        start[sel] = 1'b1;
        @(posedge clk);
        #1 start[sel] = 1'b0;
        for (int e = 0; e < 64 && !got_done; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (s_rd) begin
                check({nm, " rd_addr"}, longint'(s_addr), longint'(nrd));
                nrd++;
            end
            if (s_en) begin
                if (first_e < 0) begin
                    first_e = e;
                    first_d = longint'(s_d);
                end
                last_e = e;
                nen++;
                check({nm, " busy during stream"}, longint'(s_busy), 1);
                if (sb.size() == 0) check({nm, " extra pixel"}, 1, 0);
                else check({nm, " data"}, longint'(s_d), longint'(sb.pop_front()));
            end else if (s_d != 0) begin
                check({nm, " data while invalid"}, longint'(s_d), 0);
            end
            if (s_done) begin
                got_done = 1;
                check({nm, " done latency"}, longint'(e), longint'(last_e + 1));
                check({nm, " busy at done"}, longint'(s_busy), 0);
            end
        end
        check({nm, " done seen"}, longint'(got_done), 1);
        check({nm, " first o_en edge"}, longint'(first_e), 2);
        check({nm, " o_en count"}, longint'(nen), longint'(tc.len));
        check({nm, " o_en consecutive"}, longint'(last_e - first_e + 1), longint'(tc.len));
        check({nm, " read count"}, longint'(nrd), longint'(tc.reads));
        check({nm, " scoreboard empty"}, longint'(sb.size()), 0);
    endtask

    initial begin
        longint fd;
        int nen5, runs, gap, runlen, dones;
        bit prev_en;

        tbl[0] = '0; tbl[0].inst = 0; tbl[0].len = 9; tbl[0].reads = 9;
        for (int i = 0; i < 9; i++) begin
            tbl[0].mem[i] = 30'(i + 1);
            tbl[0].exp[i] = 30'(i + 1);
        end
        tbl[1] = '0; tbl[1].inst = 1; tbl[1].len = 16; tbl[1].reads = 4;
        for (int i = 0; i < 4; i++) tbl[1].mem[i] = 30'(10 + i);
        for (int i = 0; i < 16; i++) tbl[1].exp[i] = 30'(pat1[i]);
        tbl[2] = '0; tbl[2].inst = 0;
        for (int i = 0; i < 9; i++) tbl[2].mem[i] = 30'($urandom);
        tbl[2].mem[0] = -30'sd5;
        model(tbl[2]);
        tbl[3] = '0; tbl[3].inst = 2; tbl[3].len = 1; tbl[3].reads = 1;
        tbl[3].mem[0] = 30'd7; tbl[3].exp[0] = 30'd7;
        tbl[4] = '0; tbl[4].inst = 1;
        for (int i = 0; i < 9; i++) tbl[4].mem[i] = 30'($urandom);
        model(tbl[4]);
        tbl[5] = '0; tbl[5].inst = 0;
        for (int i = 0; i < 9; i++) tbl[5].mem[i] = 30'($urandom);
        model(tbl[5]);

        rst_n = 3'b000;
        start = 3'b000;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 chk_idle($sformatf("reset inst%0d", i));
        end
        @(negedge clk);
        rst_n = 3'b111;

        for (int k = 0; k < 6; k++) begin
            run_frame(tbl[k], $sformatf("case%0d", k), fd);
            if (k == 2) check("negative first pixel", fd, longint'($signed(30'h3FFFFFFB)));
            repeat (2) @(posedge clk);
        end

        sel = 0;
        load(tbl[0]);
        sb.delete();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 9; i++) sb.push_back($signed(tbl[0].exp[i]));
        runs = 0; gap = 0; runlen = 0; dones = 0; prev_en = 0;
        @(negedge clk);
        start[0] = 1'b1;
        for (int e = 0; e < 100 && dones < 2; e++) begin
            @(posedge clk);
            #1;
            if (s_en) begin
                if (!prev_en && runs > 0) check("held start gap>=2", longint'(gap >= 2), 1);
                if (!prev_en) begin
                    runs++;
                    runlen = 0;
                end
                runlen++;
                if (sb.size() == 0) check("held start extra pixel", 1, 0);
                else check("held start data", longint'(s_d), longint'(sb.pop_front()));
                gap = 0;
            end else begin
                if (prev_en) check("held start run length", longint'(runlen), 9);
                gap++;
            end
            if (s_done) dones++;
            prev_en = s_en;
        end
        start[0] = 1'b0;
        check("held start frames", longint'(dones), 2);
        check("held start runs", longint'(runs), 2);
        check("held start scoreboard empty", longint'(sb.size()), 0);
        repeat (6) begin
            @(posedge clk);
            #1 check("held start no third frame", longint'(s_en | s_busy), 0);
        end

        sel = 0;
        load(tbl[5]);
        nen5 = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        for (int e = 0; e < 20 && nen5 < 5; e++) begin
            @(posedge clk);
            #1 if (s_en) nen5++;
        end
        check("mid-frame 5th o_en reached", longint'(nen5), 5);
        rst_n[0] = 1'b0;
        #1 chk_idle("mid-frame reset");
        @(negedge clk);
        rst_n[0] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1 check("no resume after reset", longint'(s_en | s_busy | s_rd), 0);
        end
        run_frame(tbl[0], "after reset", fd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
